databus_arbiter: RTL and testbench

- Two-master arbiter for the shared data bus: CPU core (master 0) and debug/DMA engine (master 1).
- Sits between the masters and the address-decoded peripheral bus (data memory, GPIO, timer, terminal).
- Serialises accesses, drives exactly one read or write transaction downstream at a time, and returns read data with a completion pulse.
- Uses round-robin fairness and includes a slave-timeout watchdog so a hung device cannot stall either master.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/rr_pick2.sv | 12 +
 rtl/databus_arbiter.sv | 140 ++++++++++++++
 tb/tb_databus_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the two-master data bus arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_B = 2'd0;
  localparam logic [1:0] MODE_H = 2'd1;
  localparam logic [1:0] MODE_W = 2'd2;

  // One captured master request; held stable for the whole transaction.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mode;
  } req_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin select: on a tie the master that was not served last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_idx,
  output logic       grant_valid
);

  assign grant_valid = |req;
  assign grant_idx   = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/databus_arbiter.sv
// Two-master data bus arbiter: one downstream transaction at a time, round-robin
// grants, and a slave-timeout watchdog that answers a hung access with ERR_DATA.
module databus_arbiter
  import arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [1:0]  m0_mode,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m1_mode,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        bus_r_en,
  output logic [31:0] bus_r_addr,
  output logic [1:0]  bus_r_mode,
  input  logic [31:0] bus_r_data,
  output logic        bus_w_en,
  output logic [31:0] bus_w_addr,
  output logic [31:0] bus_w_data,
  output logic [1:0]  bus_w_mode,
  input  logic        s_ready,
  output logic        owner,
  output logic        busy
);

  localparam bit         WATCHDOG_ON  = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  req_t        txn, m0_fields, m1_fields;
  logic        last;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [7:0]  wd_cnt;
  logic        grant_idx, grant_valid;
  logic        timeout_hit;
  logic        active, resp;

  assign m0_fields = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, mode: m0_mode};
  assign m1_fields = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, mode: m1_mode};

  rr_pick2 u_pick (
    .req         ({m1_req, m0_req}),
    .last        (last),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // wd_cnt counts WAIT cycles already spent, so this fires on the TIMEOUT_CYCLES-th one.
  assign timeout_hit = WATCHDOG_ON && (wd_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (s_ready || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      txn     <= '0;
      owner   <= 1'b0;
      busy    <= 1'b0;
      last    <= 1'b1;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          txn   <= grant_idx ? m1_fields : m0_fields;
          owner <= grant_idx;
          busy  <= 1'b1;
        end
        WAIT: begin
          wd_cnt <= (wd_cnt == 8'hFF) ? wd_cnt : wd_cnt + 8'd1;
          if (s_ready) begin
            rdata_q <= txn.we ? '0 : bus_r_data;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= ERR_DATA;
            err_q   <= 1'b1;
          end
        end
        RESP: begin
          last    <= owner;
          wd_cnt  <= '0;
          busy    <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Downstream fields are forced to zero whenever their enable is low.
  assign active     = (state == ISSUE) || (state == WAIT);
  assign bus_r_en   = active && !txn.we;
  assign bus_w_en   = active && txn.we;
  assign bus_r_addr = bus_r_en ? txn.addr  : '0;
  assign bus_r_mode = bus_r_en ? txn.mode  : '0;
  assign bus_w_addr = bus_w_en ? txn.addr  : '0;
  assign bus_w_data = bus_w_en ? txn.wdata : '0;
  assign bus_w_mode = bus_w_en ? txn.mode  : '0;

  assign resp     = (state == RESP);
  assign m0_ack   = resp && !owner;
  assign m1_ack   = resp && owner;
  assign m0_rdata = m0_ack ? rdata_q : '0;
  assign m1_rdata = m1_ack ? rdata_q : '0;
  assign m0_err   = m0_ack && err_q;
  assign m1_err   = m1_ack && err_q;

endmodule

// File: tb/tb_databus_arbiter.sv
// Self-checking bench for databus_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed latencies, data and grant order.
module tb_databus_arbiter;
  import arb_pkg::*;

  localparam int          TO   = 4;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]  m0_mode, m1_mode;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        bus_r_en, bus_w_en, s_ready, owner, busy;
  logic [31:0] bus_r_addr, bus_r_data, bus_w_addr, bus_w_data;
  logic [1:0]  bus_r_mode, bus_w_mode;

  always #5 clk = ~clk;

  databus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mode(m0_mode),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mode(m1_mode),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .bus_r_en(bus_r_en), .bus_r_addr(bus_r_addr), .bus_r_mode(bus_r_mode), .bus_r_data(bus_r_data),
    .bus_w_en(bus_w_en), .bus_w_addr(bus_w_addr), .bus_w_data(bus_w_data), .bus_w_mode(bus_w_mode),
    .s_ready(s_ready), .owner(owner), .busy(busy)
  );

  int checks = 0, failures = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    return '{we: we, addr: addr, wdata: wdata, mode: MODE_W};
  endfunction

  always @(posedge clk) cyc++;

  // Masters: each holds the head of its queue on the bus until it sees its ack.
  req_t q0[$], q1[$];
  bit   pop0 = 0, pop1 = 0;
  int   t_req = 0;

  initial begin
    m0_req = 0; m1_req = 0;
    {m0_we, m0_addr, m0_wdata, m0_mode} = '0;
    {m1_we, m1_addr, m1_wdata, m1_mode} = '0;
    forever begin
      @(posedge clk); #1;
      if (pop0 && q0.size() != 0) void'(q0.pop_front());
      if (pop1 && q1.size() != 0) void'(q1.pop_front());
      pop0 = 0; pop1 = 0;
      if (q0.size() != 0) begin
        if (!m0_req) t_req = cyc;
        m0_req = 1; {m0_we, m0_addr, m0_wdata, m0_mode} = q0[0];
      end else begin
        m0_req = 0; {m0_we, m0_addr, m0_wdata, m0_mode} = '0;
      end
      if (q1.size() != 0) begin
        m1_req = 1; {m1_we, m1_addr, m1_wdata, m1_mode} = q1[0];
      end else begin
        m1_req = 0; {m1_we, m1_addr, m1_wdata, m1_mode} = '0;
      end
    end
  end

  // Slave: answers on the (delay+1)-th cycle of an enable; delay<0 means never.
  int          slave_delay = 1, en_cnt = 0;
  logic [31:0] slave_data = '0;

  initial begin
    s_ready = 0; bus_r_data = '0;
    forever begin
      @(posedge clk); #1;
      if (bus_r_en || bus_w_en) en_cnt++; else en_cnt = 0;
      s_ready    = (slave_delay >= 0) && (en_cnt == slave_delay + 1);
      bus_r_data = slave_data;
    end
  end

  // Ack monitor.
  int          acks[2] = '{0, 0};
  int          owner_log[$], ack_times[$];
  logic [31:0] last_rdata = '0;
  logic        last_err = 0;
  int          t_ack = 0;

  always @(negedge clk) begin
    if (m0_ack === 1'b1) begin
      acks[0]++; owner_log.push_back(0); ack_times.push_back(cyc);
      last_rdata = m0_rdata; last_err = m0_err; t_ack = cyc; pop0 = 1;
    end
    if (m1_ack === 1'b1) begin
      acks[1]++; owner_log.push_back(1); ack_times.push_back(cyc);
      last_rdata = m1_rdata; last_err = m1_err; t_ack = cyc; pop1 = 1;
    end
  end

  // Transaction model: tracks how many cycles the granted request has been on the bus.
  bit          mvalid = 0, mbusy = 0, mresp = 0, mown = 0, mlast = 1, merr = 0;
  int          mage = 0;
  req_t        mtx = '0;
  logic [31:0] mrd = '0;

  always @(posedge clk) begin
    if (rst) begin
      mvalid = 1; mbusy = 0; mresp = 0; mlast = 1; mown = 0;
      mage = 0; merr = 0; mrd = '0; mtx = '0;
    end else if (mresp) begin
      mresp = 0; mbusy = 0; mlast = mown;
    end else if (mbusy) begin
      if (mage >= 2 && s_ready) begin
        mresp = 1; mrd = mtx.we ? 32'h0 : bus_r_data; merr = 0;
      end else if (mage >= 2 && TO != 0 && mage - 1 == TO) begin
        mresp = 1; mrd = ERRD; merr = 1;
      end else mage++;
    end else if (m0_req || m1_req) begin
      mown  = (m0_req && m1_req) ? !mlast : m1_req;
      mtx   = mown ? {m1_we, m1_addr, m1_wdata, m1_mode} : {m0_we, m0_addr, m0_wdata, m0_mode};
      mbusy = 1; mage = 1;
    end
  end

  logic er, ew;
  always @(negedge clk) begin
    if (mvalid) begin
      er = mbusy && !mresp && !mtx.we;
      ew = mbusy && !mresp && mtx.we;
      check("bus_r_en",   32'(bus_r_en),   32'(er));
      check("bus_w_en",   32'(bus_w_en),   32'(ew));
      check("bus_r_addr", bus_r_addr,      er ? mtx.addr : 32'h0);
      check("bus_r_mode", 32'(bus_r_mode), er ? 32'(mtx.mode) : 32'h0);
      check("bus_w_addr", bus_w_addr,      ew ? mtx.addr : 32'h0);
      check("bus_w_data", bus_w_data,      ew ? mtx.wdata : 32'h0);
      check("bus_w_mode", 32'(bus_w_mode), ew ? 32'(mtx.mode) : 32'h0);
      check("no_overlap", 32'(bus_r_en & bus_w_en), 32'h0);
      check("busy",       32'(busy),       32'(mbusy));
      if (mbusy) check("owner", 32'(owner), 32'(mown));
      check("m0_ack",   32'(m0_ack), 32'(mresp && !mown));
      check("m1_ack",   32'(m1_ack), 32'(mresp && mown));
      check("m0_rdata", m0_rdata,    (mresp && !mown) ? mrd : 32'h0);
      check("m1_rdata", m1_rdata,    (mresp && mown) ? mrd : 32'h0);
      check("m0_err",   32'(m0_err), 32'(mresp && !mown && merr));
      check("m1_err",   32'(m1_err), 32'(mresp && mown && merr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1; q0.delete(); q1.delete();
    tick(1);
    rst = 0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && (q0.size() != 0 || q1.size() != 0 || mbusy); i++) tick(1);
    check("drain", 32'(q0.size() + q1.size()), 32'h0);
  endtask

  int a0;

  initial begin
    rst = 1;
    tick(3);
    rst = 0;
    check("reset_busy",  32'(busy),  32'h0);
    check("reset_owner", 32'(owner), 32'h0);

    // Single read, slave answers in the second WAIT cycle: ack 4 cycles after the sampled request.
    slave_delay = 2; slave_data = 32'h12345678;
    q0.push_back('{we: 1'b0, addr: 32'h1004, wdata: 32'h0, mode: MODE_W});
    wait_done(60);
    check("t1_latency", 32'(t_ack - t_req), 32'd4);
    check("t1_rdata",   last_rdata,         32'h12345678);
    check("t1_err",     32'(last_err),      32'h0);
    check("t1_m1_acks", 32'(acks[1]),       32'h0);

    // Contention from reset: master 0 first, then master 1.
    do_reset();
    owner_log.delete();
    slave_delay = 1;
    q0.push_back(mk(1'b1, 32'h1000, 32'hA));
    q1.push_back(mk(1'b1, 32'h1008, 32'hB));
    wait_done(60);
    check("t2_count",  32'(owner_log.size()), 32'd2);
    check("t2_first",  32'(owner_log.size() > 0 ? owner_log[0] : 9), 32'd0);
    check("t2_second", 32'(owner_log.size() > 1 ? owner_log[1] : 9), 32'd1);

    // Continuous contention: strict alternation, one transaction per 4 cycles.
    owner_log.delete(); ack_times.delete(); acks[0] = 0; acks[1] = 0;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b1, 32'h100 + 32'(i * 4), 32'(i)));
      q1.push_back(mk(1'b1, 32'h200 + 32'(i * 4), 32'(i + 16)));
    end
    wait_done(200);
    check("t3_acks0", 32'(acks[0]), 32'd4);
    check("t3_acks1", 32'(acks[1]), 32'd4);
    for (int i = 0; i < 8; i++)
      check("t3_order", 32'(owner_log.size() > i ? owner_log[i] : 9), 32'(i % 2));
    check("t3_span", 32'(ack_times.size() == 8 ? ack_times[7] - ack_times[0] : 0), 32'd28);

    // Watchdog: master 1 read with a silent slave.
    slave_delay = -1;
    q1.push_back(mk(1'b0, 32'h2000, 32'h0));
    wait_done(60);
    check("t4_err",   32'(last_err), 32'h1);
    check("t4_rdata", last_rdata,    ERRD);

    // s_ready in the same cycle the watchdog expires: real data wins.
    slave_delay = 4; slave_data = 32'hCAFEF00D;
    q0.push_back(mk(1'b0, 32'h3000, 32'h0));
    wait_done(60);
    check("t5_err",     32'(last_err),      32'h0);
    check("t5_rdata",   last_rdata,         32'hCAFEF00D);
    check("t5_latency", 32'(t_ack - t_req), 32'd6);

    // s_ready only during ISSUE is ignored, so the access times out.
    slave_delay = 0; slave_data = 32'h55AA55AA;
    q0.push_back(mk(1'b0, 32'h3004, 32'h0));
    wait_done(60);
    check("t6_err",   32'(last_err), 32'h1);
    check("t6_rdata", last_rdata,    ERRD);

    // Reset during WAIT: transaction dropped without ack, next request served normally.
    slave_delay = -1;
    a0 = acks[0];
    q0.push_back(mk(1'b0, 32'h4000, 32'h0));
    for (int i = 0; i < 20 && !bus_r_en; i++) tick(1);
    check("t7_issued", 32'(bus_r_en), 32'h1);
    tick(1);
    do_reset();
    check("t7_busy", 32'(busy),     32'h0);
    check("t7_ren",  32'(bus_r_en), 32'h0);
    tick(8);
    check("t7_no_ack", 32'(acks[0]), 32'(a0));
    slave_delay = 1;
    q0.push_back(mk(1'b1, 32'h4004, 32'h77));
    wait_done(60);
    check("t7_after_ack", 32'(acks[0]),  32'(a0 + 1));
    check("t7_after_err", 32'(last_err), 32'h0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
